// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: pipelined RV32/RV64 immediate generator with a 2-entry output skid buffer.
// Stage p0 is the combinational decode of the incoming instruction. Stage p1 holds the
// main output register (drives the outputs) and the skid register.
// Optional feature macro: IMM_GEN_PIPE_CSR_EN (CSR address / zimm decode for SYSTEM opcodes).
module imm_gen_pipe #(
  parameter int XLEN       = 32,
  parameter int TAG_W      = 8,
  parameter int SLTIU_ZEXT = 0
) (
  input  logic              IMMP_CLOCK_50,
  input  logic              IMMP_RESET_InLow,
  input  logic              IMMP_In_Valid,
  output logic              IMMP_In_Ready,
  input  logic [31:0]       IMMP_Ins_InBUS,
  input  logic [TAG_W-1:0]  IMMP_Tag_InBUS,
  output logic              IMMP_Out_Valid,
  input  logic              IMMP_Out_Ready,
  output logic [XLEN-1:0]   IMMP_Imm_OutBUS,
  output logic [2:0]        IMMP_Fmt_OutBUS,
  output logic [TAG_W-1:0]  IMMP_Tag_OutBUS
);

  localparam logic [2:0] FMT_NONE  = 3'd0;
  localparam logic [2:0] FMT_I     = 3'd1;
  localparam logic [2:0] FMT_S     = 3'd2;
  localparam logic [2:0] FMT_B     = 3'd3;
  localparam logic [2:0] FMT_U     = 3'd4;
  localparam logic [2:0] FMT_J     = 3'd5;
  localparam logic [2:0] FMT_CSR   = 3'd6;
  localparam logic [2:0] FMT_SHAMT = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Sign-extend a 32-bit two's-complement value to XLEN (narrower fields are
  // sign-extended to 32 bits by the caller's signed argument conversion).
  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  function automatic logic [XLEN-1:0] sext12(input logic signed [11:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return sext32(w);
  endfunction

  function automatic logic [XLEN-1:0] sext13(input logic signed [12:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return sext32(w);
  endfunction

  function automatic logic [XLEN-1:0] sext21(input logic signed [20:0] v);
    logic signed [31:0] w;
    w = 32'(v);
    return sext32(w);
  endfunction

  function automatic logic [XLEN-1:0] zext12(input logic [11:0] v);
    return XLEN'(v);
  endfunction

  logic [6:0]       w_opcode_p0;
  logic [2:0]       w_funct3_p0;
  logic [5:0]       w_shamt_p0;
  logic [XLEN-1:0]  w_imm_p0;
  logic [2:0]       w_fmt_p0;
  logic             w_in_xfer;
  logic             w_main_free;

  logic             r_main_vld_p1;
  logic [XLEN-1:0]  r_main_imm_p1;
  logic [2:0]       r_main_fmt_p1;
  logic [TAG_W-1:0] r_main_tag_p1;
  logic             r_skid_vld_p1;
  logic [XLEN-1:0]  r_skid_imm_p1;
  logic [2:0]       r_skid_fmt_p1;
  logic [TAG_W-1:0] r_skid_tag_p1;

  assign w_opcode_p0 = IMMP_Ins_InBUS[6:0];
  assign w_funct3_p0 = IMMP_Ins_InBUS[14:12];
  // RV64 shifts use a 6-bit shamt; RV32 uses the low 5 bits only.
  assign w_shamt_p0  = (XLEN == 64) ? IMMP_Ins_InBUS[25:20] : {1'b0, IMMP_Ins_InBUS[24:20]};

  // ---- p0: combinational decode of the incoming instruction ----
  // Decode the immediate and its format from the opcode/funct3 fields.
  always_comb begin
    w_imm_p0 = '0;
    w_fmt_p0 = FMT_NONE;
    case (w_opcode_p0)
      OP_LOAD, OP_JALR: begin
        w_imm_p0 = sext12(IMMP_Ins_InBUS[31:20]);
        w_fmt_p0 = FMT_I;
      end
      OP_IMM: begin
        if (w_funct3_p0 == 3'b001 || w_funct3_p0 == 3'b101) begin
          w_imm_p0 = XLEN'(w_shamt_p0);
          w_fmt_p0 = FMT_SHAMT;
        end else if (w_funct3_p0 == 3'b011 && SLTIU_ZEXT != 0) begin
          w_imm_p0 = zext12(IMMP_Ins_InBUS[31:20]);
          w_fmt_p0 = FMT_I;
        end else begin
          w_imm_p0 = sext12(IMMP_Ins_InBUS[31:20]);
          w_fmt_p0 = FMT_I;
        end
      end
      OP_STORE: begin
        w_imm_p0 = sext12({IMMP_Ins_InBUS[31:25], IMMP_Ins_InBUS[11:7]});
        w_fmt_p0 = FMT_S;
      end
      OP_BRANCH: begin
        w_imm_p0 = sext13({IMMP_Ins_InBUS[31], IMMP_Ins_InBUS[7], IMMP_Ins_InBUS[30:25],
                           IMMP_Ins_InBUS[11:8], 1'b0});
        w_fmt_p0 = FMT_B;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm_p0 = sext32({IMMP_Ins_InBUS[31:12], 12'b0});
        w_fmt_p0 = FMT_U;
      end
      OP_JAL: begin
        w_imm_p0 = sext21({IMMP_Ins_InBUS[31], IMMP_Ins_InBUS[19:12], IMMP_Ins_InBUS[20],
                           IMMP_Ins_InBUS[30:21], 1'b0});
        w_fmt_p0 = FMT_J;
      end
`ifdef IMM_GEN_PIPE_CSR_EN
      OP_SYSTEM: begin
        if (w_funct3_p0 == 3'b101 || w_funct3_p0 == 3'b110 || w_funct3_p0 == 3'b111) begin
          w_imm_p0 = XLEN'(IMMP_Ins_InBUS[19:15]);
          w_fmt_p0 = FMT_CSR;
        end else if (w_funct3_p0 == 3'b001 || w_funct3_p0 == 3'b010 || w_funct3_p0 == 3'b011) begin
          w_imm_p0 = zext12(IMMP_Ins_InBUS[31:20]);
          w_fmt_p0 = FMT_CSR;
        end
      end
`else
      OP_SYSTEM: begin
        w_imm_p0 = '0;
        w_fmt_p0 = FMT_NONE;
      end
`endif
      default: begin
        w_imm_p0 = '0;
        w_fmt_p0 = FMT_NONE;
      end
    endcase
  end

  // Ready depends only on the registered skid state, so no combinational path from Out_Ready.
  assign IMMP_In_Ready = ~r_skid_vld_p1;
  assign w_in_xfer     = IMMP_In_Valid & ~r_skid_vld_p1;
  // Main register can take a new entry when empty or draining this cycle.
  assign w_main_free   = ~r_main_vld_p1 | IMMP_Out_Ready;

  // ---- p1: main output register and skid register ----
  // Refill main from skid first (FIFO order), else from the input; overflow into skid when main stalls.
  always_ff @(posedge IMMP_CLOCK_50 or negedge IMMP_RESET_InLow) begin
    if (!IMMP_RESET_InLow) begin
      r_main_vld_p1 <= 1'b0;
      r_main_imm_p1 <= '0;
      r_main_fmt_p1 <= FMT_NONE;
      r_main_tag_p1 <= '0;
      r_skid_vld_p1 <= 1'b0;
      r_skid_imm_p1 <= '0;
      r_skid_fmt_p1 <= FMT_NONE;
      r_skid_tag_p1 <= '0;
    end else if (w_main_free) begin
      if (r_skid_vld_p1) begin
        r_main_vld_p1 <= 1'b1;
        r_main_imm_p1 <= r_skid_imm_p1;
        r_main_fmt_p1 <= r_skid_fmt_p1;
        r_main_tag_p1 <= r_skid_tag_p1;
        r_skid_vld_p1 <= 1'b0;
      end else if (w_in_xfer) begin
        r_main_vld_p1 <= 1'b1;
        r_main_imm_p1 <= w_imm_p0;
        r_main_fmt_p1 <= w_fmt_p0;
        r_main_tag_p1 <= IMMP_Tag_InBUS;
      end else begin
        r_main_vld_p1 <= 1'b0;
      end
    end else if (w_in_xfer) begin
      r_skid_vld_p1 <= 1'b1;
      r_skid_imm_p1 <= w_imm_p0;
      r_skid_fmt_p1 <= w_fmt_p0;
      r_skid_tag_p1 <= IMMP_Tag_InBUS;
    end
  end

  assign IMMP_Out_Valid  = r_main_vld_p1;
  assign IMMP_Imm_OutBUS = r_main_imm_p1;
  assign IMMP_Fmt_OutBUS = r_main_fmt_p1;
  assign IMMP_Tag_OutBUS = r_main_tag_p1;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed testbench for imm_gen_pipe: an RV32 instance (SLTIU sign-extended) and an
// RV64 instance (SLTIU zero-extended) receive identical stimulus.
module tb_imm_gen_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] ins;
  logic [7:0]  tag_in;
  logic        out_ready;

  logic        in_rdy32, out_vld32;
  logic [31:0] imm32;
  logic [2:0]  fmt32;
  logic [7:0]  tag32;
  logic        in_rdy64, out_vld64;
  logic [63:0] imm64;
  logic [2:0]  fmt64;
  logic [7:0]  tag64;

  int n_chk = 0;
  int n_err = 0;

  imm_gen_pipe #(.XLEN(32), .TAG_W(8), .SLTIU_ZEXT(0)) u_dut32 (
    .IMMP_CLOCK_50    (clk),
    .IMMP_RESET_InLow (rst_n),
    .IMMP_In_Valid    (in_valid),
    .IMMP_In_Ready    (in_rdy32),
    .IMMP_Ins_InBUS   (ins),
    .IMMP_Tag_InBUS   (tag_in),
    .IMMP_Out_Valid   (out_vld32),
    .IMMP_Out_Ready   (out_ready),
    .IMMP_Imm_OutBUS  (imm32),
    .IMMP_Fmt_OutBUS  (fmt32),
    .IMMP_Tag_OutBUS  (tag32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(8), .SLTIU_ZEXT(1)) u_dut64 (
    .IMMP_CLOCK_50    (clk),
    .IMMP_RESET_InLow (rst_n),
    .IMMP_In_Valid    (in_valid),
    .IMMP_In_Ready    (in_rdy64),
    .IMMP_Ins_InBUS   (ins),
    .IMMP_Tag_InBUS   (tag_in),
    .IMMP_Out_Valid   (out_vld64),
    .IMMP_Out_Ready   (out_ready),
    .IMMP_Imm_OutBUS  (imm64),
    .IMMP_Fmt_OutBUS  (fmt64),
    .IMMP_Tag_OutBUS  (tag64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, obs, exp);
    end
  endtask

  // Drive one instruction (valid left high), then at the next falling edge check both outputs.
  task automatic run_vec(input string name, input logic [31:0] i_ins, input logic [7:0] i_tag,
                         input logic [63:0] e32, input logic [63:0] e64, input logic [2:0] efmt);
    in_valid = 1'b1;
    ins      = i_ins;
    tag_in   = i_tag;
    @(negedge clk);
    check({name, "_vld32"}, {63'd0, out_vld32}, 64'd1);
    check({name, "_imm32"}, {32'd0, imm32}, e32);
    check({name, "_fmt32"}, {61'd0, fmt32}, {61'd0, efmt});
    check({name, "_tag32"}, {56'd0, tag32}, {56'd0, i_tag});
    check({name, "_vld64"}, {63'd0, out_vld64}, 64'd1);
    check({name, "_imm64"}, imm64, e64);
    check({name, "_fmt64"}, {61'd0, fmt64}, {61'd0, efmt});
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    ins       = 32'h0;
    tag_in    = 8'h0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_vld",   {63'd0, out_vld32}, 64'd0);
    check("rst_rdy",   {63'd0, in_rdy32},  64'd1);
    check("rst_imm",   imm64, 64'd0);
    check("rst_fmt",   {61'd0, fmt32}, 64'd0);
    check("rst_tag",   {56'd0, tag32}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Back-to-back decode vectors with Out_Ready held high
    run_vec("addi",  32'hFFF00093, 8'h11, 64'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1);
    run_vec("beq",   32'hFE000EE3, 8'h12, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3);
    run_vec("jal",   32'h0080006F, 8'h13, 64'h00000008, 64'h0000000000000008, 3'd5);
    run_vec("lui",   32'h800000B7, 8'h14, 64'h80000000, 64'hFFFFFFFF80000000, 3'd4);
    run_vec("slli",  32'h03F09093, 8'h15, 64'd31,       64'd63,               3'd7);
    run_vec("sltiu", 32'hFFF03093, 8'h16, 64'hFFFFFFFF, 64'h0000000000000FFF, 3'd1);
    run_vec("sw",    32'hFE20AC23, 8'h17, 64'hFFFFFFF8, 64'hFFFFFFFFFFFFFFF8, 3'd2);
    run_vec("srai",  32'h4010D093, 8'h18, 64'd1,        64'd1,                3'd7);
    run_vec("add",   32'h00000033, 8'h19, 64'd0,        64'd0,                3'd0);
    run_vec("auipc", 32'h00001097, 8'h1A, 64'h00001000, 64'h0000000000001000, 3'd4);
    run_vec("jalr",  32'hFFC08067, 8'h1B, 64'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd1);
    run_vec("ecall", 32'h00000073, 8'h1C, 64'd0,        64'd0,                3'd0);
`ifdef IMM_GEN_PIPE_CSR_EN
    run_vec("csrrw",  32'h300110F3, 8'h1D, 64'h300, 64'h300, 3'd6);
    run_vec("csrrwi", 32'h3002D0F3, 8'h1E, 64'd5,   64'd5,   3'd6);
`else
    run_vec("csrrw",  32'h300110F3, 8'h1D, 64'd0, 64'd0, 3'd0);
    run_vec("csrrwi", 32'h3002D0F3, 8'h1E, 64'd0, 64'd0, 3'd0);
`endif
    in_valid = 1'b0;
    @(negedge clk);
    check("drain_vld", {63'd0, out_vld32}, 64'd0);

    // Backpressure: push tags 1,2,3 with Out_Ready low
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ins       = 32'hFFF00093;
    tag_in    = 8'd1;
    @(negedge clk);
    check("bp_rdy_after1", {63'd0, in_rdy32}, 64'd1);
    tag_in = 8'd2;
    @(negedge clk);
    check("bp_rdy_after2", {63'd0, in_rdy32}, 64'd0);
    check("bp_rdy64_after2", {63'd0, in_rdy64}, 64'd0);
    check("bp_tag_hold1", {56'd0, tag32}, 64'd1);
    tag_in = 8'd3;
    @(negedge clk);
    check("bp_stall_rdy", {63'd0, in_rdy32}, 64'd0);
    check("bp_stall_tag", {56'd0, tag32}, 64'd1);
    check("bp_stall_vld", {63'd0, out_vld32}, 64'd1);
    check("bp_stall_imm", imm64, 64'hFFFFFFFFFFFFFFFF);
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out2_vld", {63'd0, out_vld32}, 64'd1);
    check("bp_out2_tag", {56'd0, tag32}, 64'd2);
    check("bp_rdy_back", {63'd0, in_rdy32}, 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out3_vld", {63'd0, out_vld32}, 64'd1);
    check("bp_out3_tag", {56'd0, tag32}, 64'd3);
    @(negedge clk);
    check("bp_empty_vld", {63'd0, out_vld32}, 64'd0);

    // Asynchronous reset with both entries full
    out_ready = 1'b0;
    in_valid  = 1'b1;
    ins       = 32'h0080006F;
    tag_in    = 8'd4;
    @(negedge clk);
    tag_in = 8'd5;
    @(negedge clk);
    in_valid = 1'b0;
    check("full_rdy", {63'd0, in_rdy32}, 64'd0);
    check("full_vld", {63'd0, out_vld32}, 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld32", {63'd0, out_vld32}, 64'd0);
    check("arst_vld64", {63'd0, out_vld64}, 64'd0);
    check("arst_rdy",   {63'd0, in_rdy32},  64'd1);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_vld", {63'd0, out_vld32}, 64'd0);
    check("post_rst_tag", {56'd0, tag32}, 64'd0);
    check("post_rst_rdy", {63'd0, in_rdy64}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule
